obl_sequencer: RTL

- Digit-serial compute sequencer for the keypad calculator.
- Started by the main key FSM while it sits in its compute state. Latches the two 4-digit BCD operand registers and the selected operation.
- Runs one BCD digit per clock through an internal single-digit adder/logic unit, least significant digit first.
- Returns the result plus the end_obl completion level that lets the key FSM return to waiting for a press.

---
 rtl/obl_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/obl_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : obl_sequencer
// Purpose : Digit-serial BCD compute sequencer (ADD/SUB/AND/OR/XOR/pass), LSD first.
// Revision: 1.0 - initial release
// ============================================================================
module obl_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [2:0]            op,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic [4*DIGITS-1:0]   result,
    output logic                  ovf,
    output logic                  neg,
    output logic                  busy,
    output logic                  end_obl
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [2:0] SL_ADD = 3'd0;
    localparam logic [2:0] SL_SUB = 3'd1;
    localparam logic [2:0] SL_AND = 3'd2;
    localparam logic [2:0] SL_OR  = 3'd3;
    localparam logic [2:0] SL_XOR = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    result_q, result_d;
    logic            ovf_q, ovf_d, neg_q, neg_d;
    logic            busy_q, busy_d, end_obl_q, end_obl_d;

    logic [3:0]      dig_a, dig_b, res_dig;
    logic [3:0]      x, y, nib, digit;
    logic [2:0]      eff_op;
    logic [4:0]      sum, diff;
    logic            c_out;
    logic            last;

    always_comb begin
        dig_a   = '0;
        dig_b   = '0;
        res_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                dig_a   = a_q[4*i +: 4];
                dig_b   = b_q[4*i +: 4];
                res_dig = result_q[4*i +: 4];
            end
        end
    end

    // FIX reuses the subtractor as 0 - result_i - borrow to undo the ten's complement.
    always_comb begin
        x      = dig_a;
        y      = dig_b;
        eff_op = op_q;
        if (state_q == S_FIX) begin
            x      = 4'd0;
            y      = res_dig;
            eff_op = SL_SUB;
        end
        sum   = {1'b0, x} + {1'b0, y} + {4'd0, carry_q};
        diff  = {1'b0, x} - {1'b0, y} - {4'd0, carry_q};
        nib   = 4'd0;
        digit = x;
        c_out = 1'b0;
        case (eff_op)
            SL_ADD: begin
                if (sum > 5'd9) begin
                    digit = 4'(sum - 5'd10);
                    c_out = 1'b1;
                end else begin
                    digit = sum[3:0];
                end
            end
            SL_SUB: begin
                if (diff[4]) begin
                    digit = 4'(diff + 5'd10);
                    c_out = 1'b1;
                end else begin
                    digit = diff[3:0];
                end
            end
            SL_AND, SL_OR, SL_XOR: begin
                if (eff_op == SL_AND)     nib = x & y;
                else if (eff_op == SL_OR) nib = x | y;
                else                      nib = x ^ y;
                digit = (nib > 4'd9) ? (nib - 4'd10) : nib;
            end
            default: digit = x;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        last     = (cnt_q == CW'(DIGITS - 1));
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    a_d     = a_bcd;
                    b_d     = b_bcd;
                    op_d    = op;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    neg_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN, S_FIX: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt_q == CW'(i)) result_d[4*i +: 4] = digit;
                    end
                    carry_d = c_out;
                    cnt_d   = cnt_q + CW'(1);
                    if (last) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                        if (state_q == S_FIX) begin
                            neg_d = 1'b1;
                        end else if (op_q == SL_ADD) begin
                            ovf_d = c_out;
                        end else if (op_q == SL_SUB && c_out) begin
                            carry_d = 1'b0;
                            state_d = S_FIX;
                        end
                    end
                end
            end
            default: begin
                if (!req) state_d = S_IDLE;
            end
        endcase
        busy_d    = (state_d == S_RUN) || (state_d == S_FIX);
        end_obl_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            end_obl_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            end_obl_q <= end_obl_d;
        end
    end

    assign result  = result_q;
    assign ovf     = ovf_q;
    assign neg     = neg_q;
    assign busy    = busy_q;
    assign end_obl = end_obl_q;

endmodule
`default_nettype wire
